// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pkg
// Description : Shared types and constants for the IF/ID fetch buffer.
//               - c_bubble_instr_default : default bubble instruction word
//               - fetch_entry_t          : {valid, instr, pc, pc4} record
//               - bubble_entry()         : reset/flush value of an entry
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_pkg;

   localparam logic [31:0] c_bubble_instr_default = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } fetch_entry_t;

   // Empty entry carrying the bubble instruction and zeroed PCs.
   function automatic fetch_entry_t bubble_entry(input logic [31:0] bubble_instr);
      fetch_entry_t e;
      e.valid = 1'b0;
      e.instr = bubble_instr;
      e.pc    = 32'h0000_0000;
      e.pc4   = 32'h0000_0000;
      return e;
   endfunction

endpackage : if_id_pkg
`default_nettype wire

// File: rtl/if_id_fetch_buffer_skid.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_reg
// Description : One-entry skid register. Parks the memory response that
//               arrives while the ID stage is stalled so it can be delivered
//               once the stall releases.
// Ports       : clk_i      - clock (rising edge)
//               rst_ni     - asynchronous active-low reset
//               capture_i  - write entry_i into the register (sets valid)
//               drain_i    - entry consumed by ID (clears valid)
//               clear_i    - redirect: discard the entry
//               entry_i    - instruction/pc/pc4 to park
//               entry_o    - current register contents
//               ovf_o      - sticky flag: capture while already full
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_reg
   import if_id_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INSTR = c_bubble_instr_default
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         capture_i,
   input  logic         drain_i,
   input  logic         clear_i,
   input  fetch_entry_t entry_i,
   output fetch_entry_t entry_o,
   output logic         ovf_o
);

   fetch_entry_t s_q, s_d;
   logic         ovf_q, ovf_d;

   always_comb begin
      s_d   = s_q;
      ovf_d = ovf_q;
      if (clear_i) begin
         s_d.valid = 1'b0;
      end else if (capture_i) begin
         // A second capture before the first drained would lose an
         // instruction; flag it and keep the newest response.
         if (s_q.valid) begin
            ovf_d = 1'b1;
         end
         s_d       = entry_i;
         s_d.valid = 1'b1;
      end else if (drain_i) begin
         s_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_q   <= bubble_entry(BUBBLE_INSTR);
         ovf_q <= 1'b0;
      end else begin
         s_q   <= s_d;
         ovf_q <= ovf_d;
      end
   end

   assign entry_o = s_q;
   assign ovf_o   = ovf_q;

endmodule : fetch_skid_reg
`default_nettype wire

// File: rtl/if_id_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_buffer
// Description : IF/ID boundary. Pairs each synchronous IMEM response with the
//               PC that issued it, absorbs the one-cycle memory latency across
//               stalls with a one-entry skid, and kills wrong-path fetches on
//               redirect. All outputs are registered.
// Ports       : CLK, RSTN          - clock / async active-low reset
//               PC_IF, PCadd4_IF   - PC presented to IMEM and its +4
//               IDATA              - IMEM data for the previous cycle's PC
//               stall_IFID         - hold the ID stage
//               flush_IFID         - redirect; kill in-flight fetches
//               INSTR_ID, PC_ID,
//               PCadd4_ID, VALID_ID- ID register
//               SKID_OVF           - sticky skid overflow error
//               FETCH_CNT          - instructions loaded into ID
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_buffer
   import if_id_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INSTR = c_bubble_instr_default,
   parameter int          CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [31:0]      PC_IF,
   input  logic [31:0]      PCadd4_IF,
   input  logic [31:0]      IDATA,
   input  logic             stall_IFID,
   input  logic             flush_IFID,
   output logic [31:0]      INSTR_ID,
   output logic [31:0]      PC_ID,
   output logic [31:0]      PCadd4_ID,
   output logic             VALID_ID,
   output logic             SKID_OVF,
   output logic [CNT_W-1:0] FETCH_CNT
);

   // Tracker: the fetch whose response is on IDATA this cycle.
   logic         t_valid_q;
   logic [31:0]  t_pc_q;
   logic [31:0]  t_pc4_q;

   fetch_entry_t id_q, id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   fetch_entry_t skid;
   fetch_entry_t resp;
   logic         w_capture;
   logic         w_drain;

   assign resp.valid = t_valid_q;
   assign resp.instr = IDATA;
   assign resp.pc    = t_pc_q;
   assign resp.pc4   = t_pc4_q;

   // Response arriving during a stall must be parked; it is drained on the
   // first non-stall, non-flush edge.
   assign w_capture = stall_IFID && !flush_IFID && t_valid_q;
   assign w_drain   = !stall_IFID && !flush_IFID && skid.valid;

   fetch_skid_reg #(
      .BUBBLE_INSTR (BUBBLE_INSTR)
   ) u_skid (
      .clk_i     (CLK),
      .rst_ni    (RSTN),
      .capture_i (w_capture),
      .drain_i   (w_drain),
      .clear_i   (flush_IFID),
      .entry_i   (resp),
      .entry_o   (skid),
      .ovf_o     (SKID_OVF)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         t_valid_q <= 1'b0;
         t_pc_q    <= 32'h0000_0000;
         t_pc4_q   <= 32'h0000_0000;
      end else begin
         // A stalled cycle re-presents a held PC; it is not a new fetch.
         t_valid_q <= !stall_IFID && !flush_IFID;
         t_pc_q    <= PC_IF;
         t_pc4_q   <= PCadd4_IF;
      end
   end

   always_comb begin
      id_d  = id_q;
      cnt_d = cnt_q;
      if (flush_IFID) begin
         id_d.valid = 1'b0;
         id_d.instr = BUBBLE_INSTR;
      end else if (stall_IFID) begin
         id_d = id_q;
      end else if (skid.valid) begin
         // Skid holds the older instruction; T is never valid here.
         id_d       = skid;
         id_d.valid = 1'b1;
         cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (t_valid_q) begin
         id_d  = resp;
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         // Bubble keeps the last PCs for debug visibility.
         id_d.valid = 1'b0;
         id_d.instr = BUBBLE_INSTR;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         id_q  <= bubble_entry(BUBBLE_INSTR);
         cnt_q <= '0;
      end else begin
         id_q  <= id_d;
         cnt_q <= cnt_d;
      end
   end

   assign VALID_ID  = id_q.valid;
   assign INSTR_ID  = id_q.instr;
   assign PC_ID     = id_q.pc;
   assign PCadd4_ID = id_q.pc4;
   assign FETCH_CNT = cnt_q;

endmodule : if_id_fetch_buffer
`default_nettype wire

// File: tb/tb_if_id_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fetch_buffer
// Description : Directed table-driven bench for if_id_fetch_buffer, plus an
//               asynchronous-reset sequence with the skid full. A second
//               instance with a 2-bit counter exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_buffer;

   logic        CLK;
   logic        RSTN;
   logic [31:0] PC_IF;
   logic [31:0] PCadd4_IF;
   logic [31:0] IDATA;
   logic        stall_IFID;
   logic        flush_IFID;

   logic [31:0] INSTR_ID, PC_ID, PCadd4_ID;
   logic        VALID_ID, SKID_OVF;
   logic [31:0] FETCH_CNT;

   logic [31:0] INSTR_ID2, PC_ID2, PCadd4_ID2;
   logic        VALID_ID2, SKID_OVF2;
   logic [1:0]  FETCH_CNT2;

   int checks = 0;
   int errors = 0;

   if_id_fetch_buffer #(.BUBBLE_INSTR(32'h0000_0000), .CNT_W(32)) dut (
      .CLK(CLK), .RSTN(RSTN), .PC_IF(PC_IF), .PCadd4_IF(PCadd4_IF),
      .IDATA(IDATA), .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
      .INSTR_ID(INSTR_ID), .PC_ID(PC_ID), .PCadd4_ID(PCadd4_ID),
      .VALID_ID(VALID_ID), .SKID_OVF(SKID_OVF), .FETCH_CNT(FETCH_CNT)
   );

   if_id_fetch_buffer #(.BUBBLE_INSTR(32'h0000_0000), .CNT_W(2)) dut2 (
      .CLK(CLK), .RSTN(RSTN), .PC_IF(PC_IF), .PCadd4_IF(PCadd4_IF),
      .IDATA(IDATA), .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
      .INSTR_ID(INSTR_ID2), .PC_ID(PC_ID2), .PCadd4_ID(PCadd4_ID2),
      .VALID_ID(VALID_ID2), .SKID_OVF(SKID_OVF2), .FETCH_CNT(FETCH_CNT2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous IMEM: data for the address presented at an edge appears
   // after that edge.
   always @(posedge CLK) IDATA <= PC_IF ^ 32'hA5A5_0000;

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] pc;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_pc4;
      logic [31:0] exp_instr;
      logic [31:0] exp_cnt;
   } vec_t;

   localparam logic [31:0] BUB = 32'h0000_0000;
   vec_t vecs[23];

   function automatic logic [31:0] im(input logic [31:0] p);
      return p ^ 32'hA5A5_0000;
   endfunction

   function automatic vec_t mk(input logic s, input logic f, input logic [31:0] pc,
                               input logic v, input logic [31:0] epc,
                               input logic [31:0] epc4, input logic [31:0] ein,
                               input logic [31:0] ecnt);
      vec_t r;
      r.stall = s; r.flush = f; r.pc = pc; r.exp_valid = v;
      r.exp_pc = epc; r.exp_pc4 = epc4; r.exp_instr = ein; r.exp_cnt = ecnt;
      return r;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic v, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic [31:0] ins,
                          input logic [31:0] cnt);
      chk("VALID_ID", idx, {31'd0, VALID_ID}, {31'd0, v});
      chk("PC_ID", idx, PC_ID, pc);
      chk("PCadd4_ID", idx, PCadd4_ID, pc4);
      chk("INSTR_ID", idx, INSTR_ID, ins);
      chk("FETCH_CNT", idx, FETCH_CNT, cnt);
      chk("SKID_OVF", idx, {31'd0, SKID_OVF}, 32'd0);
      chk("FETCH_CNT_wrap", idx, {30'd0, FETCH_CNT2}, {30'd0, cnt[1:0]});
   endtask

   initial begin
      // Straight-line from PC 0
      vecs[0]  = mk(0, 0, 32'h00, 0, 32'h00, 32'h00, BUB, 0);
      vecs[1]  = mk(0, 0, 32'h04, 1, 32'h00, 32'h04, im(32'h00), 1);
      vecs[2]  = mk(0, 0, 32'h08, 1, 32'h04, 32'h08, im(32'h04), 2);
      // Single-cycle stall with PC 8 in flight
      vecs[3]  = mk(1, 0, 32'h0C, 1, 32'h04, 32'h08, im(32'h04), 2);
      vecs[4]  = mk(0, 0, 32'h0C, 1, 32'h08, 32'h0C, im(32'h08), 3);
      vecs[5]  = mk(0, 0, 32'h10, 1, 32'h0C, 32'h10, im(32'h0C), 4);
      vecs[6]  = mk(0, 0, 32'h14, 1, 32'h10, 32'h14, im(32'h10), 5);
      // Three-cycle stall with PC 0x14 in flight
      vecs[7]  = mk(1, 0, 32'h18, 1, 32'h10, 32'h14, im(32'h10), 5);
      vecs[8]  = mk(1, 0, 32'h18, 1, 32'h10, 32'h14, im(32'h10), 5);
      vecs[9]  = mk(1, 0, 32'h18, 1, 32'h10, 32'h14, im(32'h10), 5);
      vecs[10] = mk(0, 0, 32'h18, 1, 32'h14, 32'h18, im(32'h14), 6);
      vecs[11] = mk(0, 0, 32'h1C, 1, 32'h18, 32'h1C, im(32'h18), 7);
      vecs[12] = mk(0, 0, 32'h20, 1, 32'h1C, 32'h20, im(32'h1C), 8);
      // Flush with 0x20 in flight, redirect to 0x100
      vecs[13] = mk(0, 1, 32'h100, 0, 32'h1C, 32'h20, BUB, 8);
      vecs[14] = mk(0, 0, 32'h100, 0, 32'h1C, 32'h20, BUB, 8);
      vecs[15] = mk(0, 0, 32'h104, 1, 32'h100, 32'h104, im(32'h100), 9);
      vecs[16] = mk(0, 0, 32'h108, 1, 32'h104, 32'h108, im(32'h104), 10);
      // Stall fills skid, then flush+stall together; redirect to 0x200
      vecs[17] = mk(1, 0, 32'h10C, 1, 32'h104, 32'h108, im(32'h104), 10);
      vecs[18] = mk(1, 1, 32'h200, 0, 32'h104, 32'h108, BUB, 10);
      vecs[19] = mk(0, 0, 32'h200, 0, 32'h104, 32'h108, BUB, 10);
      vecs[20] = mk(0, 0, 32'h204, 1, 32'h200, 32'h204, im(32'h200), 11);
      vecs[21] = mk(0, 0, 32'h208, 1, 32'h204, 32'h208, im(32'h204), 12);
      // Stall with 0x208 in flight: skid now full
      vecs[22] = mk(1, 0, 32'h20C, 1, 32'h204, 32'h208, im(32'h204), 12);

      RSTN = 1'b0; PC_IF = 32'h0; PCadd4_IF = 32'h4;
      stall_IFID = 1'b0; flush_IFID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk_all(-1, 1'b0, 32'h0, 32'h0, BUB, 32'd0);

      @(negedge CLK);
      RSTN = 1'b1;
      for (int i = 0; i < 23; i++) begin
         PC_IF      = vecs[i].pc;
         PCadd4_IF  = vecs[i].pc + 32'd4;
         stall_IFID = vecs[i].stall;
         flush_IFID = vecs[i].flush;
         @(posedge CLK);
         #1;
         chk_all(i, vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_pc4,
                 vecs[i].exp_instr, vecs[i].exp_cnt);
         @(negedge CLK);
      end

      // Async reset mid-cycle with the skid full: outputs clear without an edge.
      #1;
      RSTN = 1'b0;
      #1;
      chk_all(100, 1'b0, 32'h0, 32'h0, BUB, 32'd0);

      // Release: skid content must not reappear.
      @(negedge CLK);
      RSTN = 1'b1;
      PC_IF = 32'h300; PCadd4_IF = 32'h304;
      stall_IFID = 1'b0; flush_IFID = 1'b0;
      @(posedge CLK);
      #1;
      chk_all(101, 1'b0, 32'h0, 32'h0, BUB, 32'd0);
      @(negedge CLK);
      PC_IF = 32'h304; PCadd4_IF = 32'h308;
      @(posedge CLK);
      #1;
      chk_all(102, 1'b1, 32'h300, 32'h304, im(32'h300), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_if_id_fetch_buffer
`default_nettype wire

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
IF/ID boundary block. It pairs each synchronous instruction-memory response with the PC that issued it, and delivers the result to the decode stage as a valid-qualified ID register. It absorbs the one-cycle memory latency across stalls using a single-entry skid buffer, so no fetched instruction is lost or duplicated. It also kills wrong-path fetches on redirect.

Parameters:
BUBBLE_INSTR, 32'h0000_0000, instruction word driven on INSTR_ID when VALID_ID=0
CNT_W, 32, width of the delivered-instruction counter

Ports:
CLK  input  1  single system clock, rising edge
RSTN  input  1  asynchronous active-low reset
PC_IF  input  32  PC currently presented to IMEM by the fetch stage
PCadd4_IF  input  32  PC_IF+4 from the fetch stage
IDATA  input  32  IMEM read data; valid one cycle after its IADDR
stall_IFID  input  1  hazard stall; same cycle-timing as the fetch-stage PC stall
flush_IFID  input  1  redirect (jump in ID or taken branch in EX) this cycle
INSTR_ID  output  32  instruction in ID
PC_ID  output  32  PC of INSTR_ID
PCadd4_ID  output  32  PC+4 of INSTR_ID
VALID_ID  output  1  ID holds a real instruction (0 = bubble)
SKID_OVF  output  1  sticky error: skid write while already full
FETCH_CNT  output  CNT_W  count of instructions loaded into ID

Behaviour:
- Reset (async, RSTN=0): all state valid bits = 0; VALID_ID=0; INSTR_ID=BUBBLE_INSTR; PC_ID=PCadd4_ID=0; SKID_OVF=0; FETCH_CNT=0. Deassertion takes effect on the next rising edge.
- Tracker T {valid, pc, pc4}: every edge, T.pc<=PC_IF and T.pc4<=PCadd4_IF.
  - T.valid<=1 only if RSTN, !stall_IFID and !flush_IFID in that cycle; otherwise 0.
  - A fetch is "accepted" only in a non-stall cycle. Repeated fetches of a held PC are ignored.
- Response pairing: in cycle t+1, IDATA belongs to T (the fetch accepted at t). Latency PC_IF to ID register is 2 edges.
- Skid S {valid, instr, pc, pc4}, one entry.
  - Capture: if stall_IFID && !flush_IFID && T.valid, then S<={1, IDATA, T.pc, T.pc4}.
  - If S.valid was already 1 at capture, set SKID_OVF (sticky until reset) and overwrite S. This cannot occur under legal stimulus.
- ID register update, in priority order:
  1. flush_IFID: VALID_ID<=0, INSTR_ID<=BUBBLE_INSTR, S.valid<=0. T is killed (its response is discarded).
  2. stall_IFID: hold all ID outputs.
  3. S.valid: ID<=S, VALID_ID<=1, S.valid<=0. When stall drops, T.valid=0 by construction, so there is no conflict with T.
  4. T.valid: ID<={IDATA, T.pc, T.pc4}, VALID_ID<=1.
  5. Otherwise: bubble (VALID_ID<=0, INSTR_ID<=BUBBLE_INSTR). PC_ID/PCadd4_ID hold their last value.
- Simultaneous flush+stall: flush wins. S and T are dropped and ID becomes a bubble.
- FETCH_CNT increments by 1 on each edge where rule 3 or rule 4 loads ID. It wraps modulo 2^CNT_W.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package if_id_pkg holds:
  - BUBBLE_INSTR default constant
  - typedef fetch_entry_t {logic valid; logic [31:0] instr, pc, pc4}
  - a function bubble_entry() returning the reset/flush value
- Sub-module fetch_skid_reg: the one-entry S register with capture, drain, clear and the overflow flag. The top level holds T, the ID register, priority muxing and FETCH_CNT.

Test Plan:
- Straight-line: reset release, no stall/flush, IMEM returns mem[PC]=PC^32'hA5A5_0000 for PC=0,4,8,...
  -> VALID_ID first 1 on the 2nd edge after release with PC_ID=0; then PC_ID=4,8,... every cycle with matching INSTR_ID; FETCH_CNT increments each cycle.
- Single-cycle stall after PC=8 accepted:
  -> S captures instr(8); ID holds PC_ID=4 for the stall edge; then PC_ID=8 from S, then PC_ID=12. No duplicate and no loss; SKID_OVF=0.
- Three-cycle stall:
  -> ID holds for 3 edges; the next three deliveries are PC 8, then 12 (re-fetched held PC accepted on the first non-stall cycle), then 16. FETCH_CNT advances exactly 1 per delivery.
- Flush with T valid (PC=0x20 in flight), new PC_IF=0x100:
  -> next edge VALID_ID=0 and INSTR_ID=BUBBLE_INSTR; following edge PC_ID=0x100. 0x20 never appears in ID.
- Flush and stall together while S is full:
  -> S cleared, VALID_ID=0, FETCH_CNT unchanged. After release the first delivery is the redirect target.
- Async reset asserted mid-stream with S full:
  -> all outputs return to reset values immediately without a clock edge; no stale delivery after RSTN rises.
